// File: rtl/host_mem_responder.sv
// Host-memory responder: independent read/write beat channels against a word store, fixed-latency ready pulses.
// Optional statistics counters are built when HOST_MEM_STATS_EN is defined; otherwise the ports read 0.
module host_mem_responder #(
  parameter int          DEPTH_LOG2 = 13,
  parameter int          LATENCY    = 2,
  parameter logic [31:0] ERR_DATA   = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] mem_base,
  input  logic        read_enable,
  input  logic [63:0] read_addr,
  input  logic        finish_read,
  output logic [63:0] read_ready,
  output logic [31:0] read_data,
  input  logic        write_enable,
  input  logic [63:0] write_addr,
  input  logic [31:0] write_data,
  input  logic        finish_write,
  output logic [63:0] write_ready,
  output logic [31:0] rd_beats,
  output logic [31:0] wr_beats,
  output logic [31:0] oob_beats
);

  localparam int WORDS = 1 << DEPTH_LOG2;
  localparam logic [63:0] SPAN = 64'd1 << (DEPTH_LOG2 + 2);
  localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  // WAIT covers the cycles strictly between acceptance and the pulse.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY >= 2) ? LATENCY - 2 : 0);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP, R_NEXT} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP, W_NEXT} w_state_t;

  function automatic logic in_range(input logic [63:0] addr, input logic [63:0] base);
    return (addr >= base) && ((addr - base) < SPAN);
  endfunction

  function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [63:0] addr, input logic [63:0] base);
    return DEPTH_LOG2'((addr - base) >> 2);
  endfunction

  logic [31:0] mem [0:WORDS-1];

  r_state_t              r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [DEPTH_LOG2-1:0] r_idx_q;
  logic                  r_oob_q;
  logic                  rd_pulse;

  w_state_t              w_state;
  logic [CNT_W-1:0]      w_cnt;
  logic [DEPTH_LOG2-1:0] w_idx_q;
  logic                  w_oob_q;
  logic [31:0]           w_data_q;
  logic                  wr_pulse;

  logic                  r_accept, w_accept, w_commit;
  logic [DEPTH_LOG2-1:0] rd_idx_now, wr_idx_now;
  logic                  rd_oob_now, wr_oob_now;
  logic [31:0]           rd_word_now, rd_word_q;

  // A write committing on the same edge that captures read data is forwarded,
  // so a read pulsing the cycle after a write pulse sees the new word.
  always_comb begin
    w_commit    = (w_state == W_RESP) && !w_oob_q;
    r_accept    = ((r_state == R_IDLE) && read_enable) || ((r_state == R_NEXT) && finish_read);
    w_accept    = ((w_state == W_IDLE) && write_enable) || ((w_state == W_NEXT) && finish_write);
    rd_idx_now  = word_idx(read_addr, mem_base);
    rd_oob_now  = !in_range(read_addr, mem_base);
    wr_idx_now  = word_idx(write_addr, mem_base);
    wr_oob_now  = !in_range(write_addr, mem_base);
    rd_word_now = rd_oob_now ? ERR_DATA :
                  (w_commit && (w_idx_q == rd_idx_now)) ? w_data_q : mem[rd_idx_now];
    rd_word_q   = r_oob_q ? ERR_DATA :
                  (w_commit && (w_idx_q == r_idx_q)) ? w_data_q : mem[r_idx_q];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= R_IDLE;
      r_cnt     <= '0;
      rd_pulse  <= 1'b0;
      read_data <= '0;
    end else begin
      rd_pulse <= 1'b0;
      if (r_accept) begin
        r_idx_q <= rd_idx_now;
        r_oob_q <= rd_oob_now;
        if (LATENCY == 1) begin
          r_state   <= R_RESP;
          rd_pulse  <= 1'b1;
          read_data <= rd_word_now;
        end else begin
          r_state <= R_WAIT;
          r_cnt   <= CNT_LOAD;
        end
      end else begin
        case (r_state)
          R_WAIT: begin
            if (!read_enable) begin
              r_state <= R_IDLE;
            end else if (r_cnt == '0) begin
              r_state   <= R_RESP;
              rd_pulse  <= 1'b1;
              read_data <= rd_word_q;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          R_RESP:  r_state <= R_NEXT;
          R_NEXT:  if (!read_enable) r_state <= R_IDLE;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state  <= W_IDLE;
      w_cnt    <= '0;
      wr_pulse <= 1'b0;
    end else begin
      wr_pulse <= 1'b0;
      if (w_accept) begin
        w_idx_q  <= wr_idx_now;
        w_oob_q  <= wr_oob_now;
        w_data_q <= write_data;
        if (LATENCY == 1) begin
          w_state  <= W_RESP;
          wr_pulse <= 1'b1;
        end else begin
          w_state <= W_WAIT;
          w_cnt   <= CNT_LOAD;
        end
      end else begin
        case (w_state)
          W_WAIT: begin
            if (!write_enable) begin
              w_state <= W_IDLE;
            end else if (w_cnt == '0) begin
              w_state  <= W_RESP;
              wr_pulse <= 1'b1;
            end else begin
              w_cnt <= w_cnt - 1'b1;
            end
          end
          W_RESP:  w_state <= W_NEXT;
          W_NEXT:  if (!write_enable) w_state <= W_IDLE;
          default: ;
        endcase
      end
    end
  end

  // Store is not reset; a write already in W_RESP commits even if reset arrives.
  always_ff @(posedge clk) begin
    if (w_commit) mem[w_idx_q] <= w_data_q;
  end

  assign read_ready  = {63'd0, rd_pulse};
  assign write_ready = {63'd0, wr_pulse};

`ifdef HOST_MEM_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_beats  <= '0;
      wr_beats  <= '0;
      oob_beats <= '0;
    end else begin
      rd_beats  <= rd_beats + 32'(rd_pulse);
      wr_beats  <= wr_beats + 32'(wr_pulse);
      oob_beats <= oob_beats + 32'(rd_pulse & r_oob_q) + 32'(wr_pulse & w_oob_q);
    end
  end
`else
  assign rd_beats  = '0;
  assign wr_beats  = '0;
  assign oob_beats = '0;
`endif

endmodule

// File: tb/tb_host_mem_responder.sv
// Bench for host_mem_responder: table of single beats, bursts, concurrency, abort and reset sequences,
// with a cycle-stamped scoreboard checking every ready pulse.
module tb_host_mem_responder;

  localparam int          LAT  = 2;
  localparam logic [63:0] BASE = 64'h1000;
  localparam logic [63:0] TOP  = BASE + (64'd1 << 15);
  localparam logic [31:0] ERR  = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] mem_base;
  logic        read_enable, finish_read;
  logic [63:0] read_addr;
  logic [63:0] read_ready;
  logic [31:0] read_data;
  logic        write_enable, finish_write;
  logic [63:0] write_addr;
  logic [31:0] write_data;
  logic [63:0] write_ready;
  logic [31:0] rd_beats, wr_beats, oob_beats;

  host_mem_responder #(.DEPTH_LOG2(13), .LATENCY(LAT), .ERR_DATA(ERR)) dut (
    .clk(clk), .reset(reset), .mem_base(mem_base),
    .read_enable(read_enable), .read_addr(read_addr), .finish_read(finish_read),
    .read_ready(read_ready), .read_data(read_data),
    .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
    .finish_write(finish_write), .write_ready(write_ready),
    .rd_beats(rd_beats), .wr_beats(wr_beats), .oob_beats(oob_beats)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [31:0] data; } rexp_t;
  typedef struct { bit wr; logic [63:0] addr; logic [31:0] data; logic [31:0] exp; } vec_t;

  rexp_t rq[$];
  int    wq[$];
  int    checks = 0, errors = 0;
  int    exp_rd = 0, exp_wr = 0, exp_oob = 0;
  bit    mon_en = 1'b0;
  vec_t  vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit is_oob(input logic [63:0] a);
    return !(a >= BASE && a < TOP);
  endfunction

  task automatic check_stats(input string tag);
`ifdef HOST_MEM_STATS_EN
    check({tag, "_rd_beats"}, 64'(rd_beats), 64'(exp_rd));
    check({tag, "_wr_beats"}, 64'(wr_beats), 64'(exp_wr));
    check({tag, "_oob_beats"}, 64'(oob_beats), 64'(exp_oob));
`else
    check({tag, "_rd_beats"}, 64'(rd_beats), 64'd0);
    check({tag, "_wr_beats"}, 64'(wr_beats), 64'd0);
    check({tag, "_oob_beats"}, 64'(oob_beats), 64'd0);
`endif
  endtask

  // Scoreboard: every pulse must match the front entry's cycle; overdue entries are misses.
  always @(negedge clk) begin
    rexp_t e;
    if (mon_en) begin
      if (rq.size() > 0 && rq[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL read_missed: no read_ready, expected pulse at cycle %0d", rq[0].cyc);
        void'(rq.pop_front());
      end
      if (read_ready != 64'd0) begin
        if (rq.size() == 0 || rq[0].cyc != cyc) begin
          checks++; errors++;
          $display("FAIL read_unexpected: read_ready=%0d at cycle %0d, expected no pulse", read_ready, cyc);
        end else begin
          e = rq.pop_front();
          check("read_ready_val", read_ready, 64'd1);
          check("read_data", 64'(read_data), 64'(e.data));
        end
      end
      if (wq.size() > 0 && wq[0] < cyc) begin
        checks++; errors++;
        $display("FAIL write_missed: no write_ready, expected pulse at cycle %0d", wq[0]);
        void'(wq.pop_front());
      end
      if (write_ready != 64'd0) begin
        if (wq.size() == 0 || wq[0] != cyc) begin
          checks++; errors++;
          $display("FAIL write_unexpected: write_ready=%0d at cycle %0d, expected no pulse", write_ready, cyc);
        end else begin
          void'(wq.pop_front());
          check("write_ready_val", write_ready, 64'd1);
        end
      end
    end
  end

  // n beats on one channel; beats after the first are requested with finish_* in the NEXT cycle.
  task automatic burst(input bit wr, input logic [63:0] a0, input int n,
                       input logic [31:0] d0, input logic [31:0] e0);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (wr) begin
        write_enable = 1'b1;
        write_addr   = a0 + 64'(4 * i);
        write_data   = d0 + 32'(i);
        finish_write = (i > 0);
        wq.push_back(cyc + LAT);
        exp_wr++;
        if (is_oob(write_addr)) exp_oob++;
      end else begin
        read_enable = 1'b1;
        read_addr   = a0 + 64'(4 * i);
        finish_read = (i > 0);
        rq.push_back('{cyc + LAT, e0 + 32'(i)});
        exp_rd++;
        if (is_oob(read_addr)) exp_oob++;
      end
      @(posedge clk); #1;
      if (wr) finish_write = 1'b0;
      else    finish_read  = 1'b0;
      repeat (LAT - 1) @(posedge clk);
    end
    @(posedge clk); #1;
    if (wr) write_enable = 1'b0;
    else    read_enable  = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    vecs[0] = '{1'b1, 64'h100C, 32'h55,       32'h0};
    vecs[1] = '{1'b0, 64'h100C, 32'h0,        32'h55};
    vecs[2] = '{1'b0, 64'h100F, 32'h0,        32'h55};
    vecs[3] = '{1'b1, 64'h1000, 32'h11,       32'h0};
    vecs[4] = '{1'b1, 64'h8FFC, 32'hA5A5A5A5, 32'h0};
    vecs[5] = '{1'b0, 64'h8FFC, 32'h0,        32'hA5A5A5A5};
    vecs[6] = '{1'b0, 64'h0FFC, 32'h0,        ERR};
    vecs[7] = '{1'b1, 64'h9000, 32'h12345678, 32'h0};
    vecs[8] = '{1'b0, 64'h1000, 32'h0,        32'h11};

    reset = 1'b1; mem_base = BASE;
    read_enable = 1'b0; read_addr = '0; finish_read = 1'b0;
    write_enable = 1'b0; write_addr = '0; write_data = '0; finish_write = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("reset_read_ready", read_ready, 64'd0);
    check("reset_write_ready", write_ready, 64'd0);
    check("reset_read_data", 64'(read_data), 64'd0);
    check_stats("reset");

    for (int i = 0; i < 9; i++) burst(vecs[i].wr, vecs[i].addr, 1, vecs[i].data, vecs[i].exp);
    check_stats("table");

    burst(1'b1, BASE, 4, 32'd1, 32'd0);
    burst(1'b0, BASE, 4, 32'd0, 32'd1);

    // Same-cycle read and write of one word: read sees the old value.
    burst(1'b1, BASE + 64'h10, 1, 32'd7, 32'd0);
    fork
      burst(1'b0, BASE + 64'h10, 1, 32'd0, 32'd7);
      burst(1'b1, BASE + 64'h10, 1, 32'd9, 32'd0);
    join
    burst(1'b0, BASE + 64'h10, 1, 32'd0, 32'd9);

    fork
      burst(1'b0, 64'h0, 1, 32'd0, ERR);
      burst(1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 1, 32'd5, 32'd0);
    join
    check_stats("dual_oob");

    // Abort during WAIT (finish_read there is ignored), then a fresh countdown.
    @(posedge clk); #1;
    read_enable = 1'b1; read_addr = BASE + 64'h4;
    @(posedge clk); #1;
    read_enable = 1'b0; finish_read = 1'b1;
    @(posedge clk); #1;
    finish_read = 1'b0;
    @(posedge clk); #1;
    read_enable = 1'b1;
    rq.push_back('{cyc + LAT, 32'd2});
    exp_rd++;
    repeat (LAT + 1) @(posedge clk);
    #1 read_enable = 1'b0;
    @(posedge clk);

    // Reset in the middle of in-flight beats on both channels.
    burst(1'b1, BASE + 64'h14, 1, 32'h66, 32'd0);
    @(posedge clk); #1;
    write_enable = 1'b1; write_addr = BASE + 64'h14; write_data = 32'h77;
    read_enable  = 1'b1; read_addr  = BASE;
    @(posedge clk); #1;
    reset = 1'b1; write_enable = 1'b0; read_enable = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_rd = 0; exp_wr = 0; exp_oob = 0;
    @(negedge clk);
    check("midreset_read_ready", read_ready, 64'd0);
    check("midreset_write_ready", write_ready, 64'd0);
    check("midreset_read_data", 64'(read_data), 64'd0);
    check_stats("midreset");
    repeat (4) @(posedge clk);
    burst(1'b0, BASE + 64'h14, 1, 32'd0, 32'h66);
    check_stats("final");

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("read_queue_drained", 64'(rq.size()), 64'd0);
    check("write_queue_drained", 64'(wq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/host_mem_responder.md
# host_mem_responder

Memory-side responder for the host read/write beat protocol used by the scratchpad front-ends. It serves a one-beat-at-a-time read channel and write channel against a word-addressed backing store. Each beat is answered after a fixed latency with a one-cycle ready pulse. It stands in for host memory in simulation and FPGA loopback builds, facing the `read_*`/`write_*` master ports of a scratchpad wrapper.

## Interface
- `DEPTH_LOG2`, default 13: backing store holds 2^DEPTH_LOG2 32-bit words.
- `LATENCY`, default 2: cycles from beat acceptance to ready pulse. Must be ≥1.
- `ERR_DATA`, default 32'hDEADBEEF: data returned for out-of-range reads.
- `clk` in 1: the only clock.
- `reset` in 1: synchronous, active-high.
- `mem_base` in 64: byte address of word 0.
- `read_enable` in 1: a read burst is active.
- `read_addr` in 64: byte address of the current read beat.
- `finish_read` in 1: one-cycle pulse requesting the next read beat.
- `read_ready` out 64: one-cycle pulse, value 1 or 0.
- `read_data` out 32: data of the last read beat.
- `write_enable` in 1: a write burst is active.
- `write_addr` in 64: byte address of the current write beat.
- `write_data` in 32: data of the current write beat.
- `finish_write` in 1: one-cycle pulse requesting the next write beat.
- `write_ready` out 64: one-cycle pulse, value 1 or 0.
- `rd_beats` out 32, `wr_beats` out 32, `oob_beats` out 32: statistics counters (see Configuration).

## Operation
- Word index = `(addr - mem_base) >> 2`, computed at 64 bits; `addr[1:0]` is ignored.
- A beat is in range iff `addr >= mem_base` and `addr < mem_base + (2^DEPTH_LOG2 << 2)`.
- Read FSM:
  - R_IDLE: when `read_enable`=1, accept the beat: latch `read_addr` and load the latency counter. Go to R_WAIT.
  - R_WAIT: counts down. If `read_enable` drops, abort to R_IDLE with no pulse. When the counter expires, go to R_RESP.
  - R_RESP: `read_ready`=1 for exactly one cycle. `read_data` is the latched word, or ERR_DATA if out of range. Go to R_NEXT.
  - R_NEXT: if `finish_read`=1, accept a new beat by latching the current `read_addr`, then go to R_WAIT. Otherwise, if `read_enable`=0, go to R_IDLE. Otherwise wait.
- Write FSM: W_IDLE/W_WAIT/W_RESP/W_NEXT behave the same way, driven by `write_enable` and `finish_write`.
  - `write_addr` and `write_data` are latched at acceptance.
  - The store is updated in the W_RESP cycle, the same cycle as the `write_ready` pulse.
  - Out-of-range writes are dropped but still pulsed.
- The two channels run independently and concurrently.
- Read and write on the same word in the same cycle: the read returns the old data (read-before-write).
- `finish_*` outside the corresponding R_NEXT/W_NEXT state is ignored.
- In R_NEXT/W_NEXT, `finish_*`=1 takes precedence over `enable`=0 in the same cycle.
- The backing store is not cleared by reset.

## Timing
- Reset values: `read_ready`=0, `write_ready`=0, `read_data`=0, all counters 0, both FSMs idle.
- Acceptance in cycle t produces the ready pulse in cycle t+LATENCY. `read_data` is valid from that cycle and held until the next R_RESP.
- Ready pulses are never wider than one cycle.
- Back-to-back beats: pulse at t, `finish_*` at t+1, next pulse at t+1+LATENCY.
- Reset asserted mid-burst: at the next edge both FSMs return to idle, no further pulse is produced, and the in-flight write is not committed unless it was already in W_RESP.

## Configuration
- Macro: `HOST_MEM_STATS_EN`.
- Defined:
  - `rd_beats` increments on each `read_ready` pulse.
  - `wr_beats` increments on each `write_ready` pulse.
  - `oob_beats` increments on each out-of-range pulse on either channel, +2 if both channels pulse out of range in the same cycle.
  - All counters wrap at 2^32 and clear on reset.
- Undefined: the three ports remain and are tied to 0, and no counter logic is built.

## Test plan
- LATENCY=2, mem_base=0x1000, word 3 preloaded with 0x55. `read_enable`=1, `read_addr`=0x100C at cycle 0 → `read_ready`=1 only in cycle 2 with `read_data`=0x55. Drop enable → FSM idle, no further pulses.
- 4-beat write burst to 0x1000 with data 1..4, `finish_write` pulsed after each pulse → 4 pulses spaced 3 cycles apart. Then a 4-beat read burst → data 1,2,3,4.
- Read of 0x0FFC and write of 0x9000 (DEPTH_LOG2=13) → read returns 0xDEADBEEF. The write pulses but the store is unchanged. `oob_beats`=2 with the macro, 0 without it.
- Read and write to 0x1010 pulsing in the same cycle, store value 7, write data 9 → read returns 7. A following read returns 9.
- `read_enable` drops during R_WAIT → no `read_ready` pulse. The next `read_enable` starts a fresh LATENCY countdown.
- `reset` asserted for 1 cycle mid-burst → ready pulses stop, outputs return to reset values, and the next burst completes normally.
